// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      HOLD      = 3'd3,
      RUN       = 3'd4
   } pll_state_e;

   // One spare bit so the per-state counter can hold the largest terminal count.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Per-PLL supervision bundle: raw lock in, PLL reset / domain reset / status out.
interface pll_seq_if #(
   parameter int N      = 1,
   parameter int LOSS_W = 8
);
   import pll_seq_pkg::*;

   // Level signals only, no valid/ready: lock is asynchronous and sampled every
   // cycle; every output is valid every cycle and is decoded from registers.
   logic [N-1:0]         lock;
   logic [N-1:0]         resetb;
   logic [N-1:0]         dom_rst;
   logic [N-1:0]         timeout;
   logic [N*LOSS_W-1:0]  loss;
   logic [N*STATE_W-1:0] state;

   modport master (input lock, output resetb, dom_rst, timeout, loss, state);
   modport slave  (output lock, input resetb, dom_rst, timeout, loss, state);

endinterface

// File: rtl/pll_lock_sequencer_channel.sv
// One supervised PLL: lock synchroniser, lock FSM, state counter, loss counter, timeout flag.
module pll_seq_channel
   import pll_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 1024,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int RETRY_CYCLES   = 64,
   parameter int LOSS_CNT_W     = 8
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      release_ok_i,
   pll_seq_if.master bus
);

   localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES, RETRY_CYCLES);

   localparam logic [STATE_W-1:0] S_RESET_PLL = RESET_PLL;
   localparam logic [STATE_W-1:0] S_WAIT_LOCK = WAIT_LOCK;
   localparam logic [STATE_W-1:0] S_STABLE    = STABLE;
   localparam logic [STATE_W-1:0] S_HOLD      = HOLD;
   localparam logic [STATE_W-1:0] S_RUN       = RUN;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   logic [STATE_W-1:0]     state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
   logic                   err_q, err_d;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      loss_d  = loss_q;
      err_d   = err_q;
      case (state_q)
         S_RESET_PLL: if (cnt_q == CNT_W'(RETRY_CYCLES - 1)) state_d = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            // A lock arriving on the timeout cycle still wins.
            if (lock_s) state_d = S_STABLE;
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_RESET_PLL;
               err_d   = 1'b1;
            end
         end
         S_STABLE: begin
            if (!lock_s) state_d = S_WAIT_LOCK;
            else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!lock_s) state_d = S_WAIT_LOCK;
            else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               if (release_ok_i) state_d = S_RUN;
               else cnt_d = cnt_q;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               if (loss_q != '1) loss_d = loss_q + 1'b1;
            end else if (!release_ok_i) state_d = S_HOLD;
         end
         default: state_d = S_RESET_PLL;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         state_q <= S_RESET_PLL;
         cnt_q   <= '0;
         loss_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.lock[0]};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         loss_q  <= loss_d;
         err_q   <= err_d;
      end
   end

   assign bus.resetb  = (state_q != S_RESET_PLL);
   assign bus.dom_rst = (state_q != S_RUN);
   assign bus.loss    = loss_q;
   assign bus.timeout = err_q;
   assign bus.state   = state_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Lock supervisor for CHANNELS iCE40 PLLs. Define PLL_SEQ_RELEASE_EN to release
// the clock domains in channel-index order; otherwise channels are independent.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int CHANNELS       = 1,
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 1024,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int RETRY_CYCLES   = 64,
   parameter int LOSS_CNT_W     = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            pll_locked,
   output logic [CHANNELS-1:0]            pll_resetb,
   output logic [CHANNELS-1:0]            domain_reset,
   output logic                           all_ready,
   output logic [CHANNELS*LOSS_CNT_W-1:0] loss_count,
   output logic [CHANNELS-1:0]            timeout_err
);

   logic [CHANNELS-1:0] run;
   logic                all_ready_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pll_seq_if #(.N(1), .LOSS_W(LOSS_CNT_W)) ch_if ();
      logic release_ok;

`ifdef PLL_SEQ_RELEASE_EN
      if (i == 0) begin : g_first
         assign release_ok = 1'b1;
      end else begin : g_chain
         // Dropping out of RUN upstream pushes this channel back to HOLD.
         assign release_ok = run[i-1];
      end
`else
      assign release_ok = 1'b1;
`endif

      assign ch_if.lock = pll_locked[i];

      pll_seq_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
         .RETRY_CYCLES  (RETRY_CYCLES),
         .LOSS_CNT_W    (LOSS_CNT_W)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .release_ok_i(release_ok),
         .bus         (ch_if)
      );

      assign pll_resetb[i]                         = ch_if.resetb[0];
      assign domain_reset[i]                       = ch_if.dom_rst[0];
      assign timeout_err[i]                        = ch_if.timeout[0];
      assign loss_count[i*LOSS_CNT_W +: LOSS_CNT_W] = ch_if.loss;
      assign run[i]                                = (ch_if.state == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) all_ready_q <= 1'b0;
      else       all_ready_q <= &run;
   end

   assign all_ready = all_ready_q;

endmodule
